// File: rtl/muldiv_pkg.sv
// Shared constants, function codes and state encoding for the iterative
// RV64M multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    // Every divide/remainder opcode has the top function bit set.
    function automatic logic is_div(input logic [2:0] func3);
        return func3[2];
    endfunction

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
    function automatic logic is_signed_a(input logic [2:0] func3);
        return (func3 == F3_MUL) || (func3 == F3_MULH) || (func3 == F3_MULHSU) ||
               (func3 == F3_DIV) || (func3 == F3_REM);
    endfunction

    // rs2 is treated as signed by MUL, MULH, DIV and REM (MULHSU keeps it unsigned).
    function automatic logic is_signed_b(input logic [2:0] func3);
        return (func3 == F3_MUL) || (func3 == F3_MULH) ||
               (func3 == F3_DIV) || (func3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> sequencer bundle: start handshake, operands, flush,
// and the result handshake with the busy indication.
interface muldiv_if;

    logic                          startValid;
    logic                          startReady;
    logic [2:0]                    func3;
    logic [muldiv_pkg::XLEN-1:0]   opA;
    logic [muldiv_pkg::XLEN-1:0]   opB;
    logic                          flush;
    logic [muldiv_pkg::XLEN-1:0]   result;
    logic                          resultValid;
    logic                          resultReady;
    logic                          busy;

    modport master (
        output startValid, func3, opA, opB, flush, resultReady,
        input  startReady, result, resultValid, busy
    );

    modport slave (
        input  startValid, func3, opA, opB, flush, resultReady,
        output startReady, result, resultValid, busy
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned magnitude results of the iterative loop into the final
// architectural result: sign correction, high/low product selection and the
// divide-by-zero / signed-overflow special values.
module muldiv_sign_fix
    import muldiv_pkg::*;
(
    input  logic [2:0]      func3_i,
    input  logic            negA_i,
    input  logic            negB_i,
    input  logic            divZero_i,
    input  logic            ovf_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    // Select and sign-correct the result for the latched operation.
    always_comb begin
        prod     = {hi_i, lo_i};
        quot     = lo_i;
        rem      = hi_i;
        result_o = '0;

        if (negA_i ^ negB_i) begin
            prod = -prod;
            quot = -lo_i;
        end
        if (negA_i) begin
            rem = -hi_i;
        end

        case (func3_i)
            F3_MUL: begin
                result_o = prod[XLEN-1:0];
            end
            F3_MULH, F3_MULHSU, F3_MULHU: begin
                result_o = prod[2*XLEN-1:XLEN];
            end
            F3_DIV, F3_DIVU: begin
                if (divZero_i) begin
                    result_o = '1;
                end else if (ovf_i) begin
                    result_o = MIN_INT;
                end else begin
                    result_o = quot;
                end
            end
            default: begin
                // On divide-by-zero the loop never ran, so lo_i still holds |A|.
                if (divZero_i) begin
                    result_o = negA_i ? -lo_i : lo_i;
                end else if (ovf_i) begin
                    result_o = '0;
                end else begin
                    result_o = rem;
                end
            end
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide unit: accepts one operation, runs a
// 64-step shift-add or restoring-division loop on operand magnitudes,
// sign-corrects in a single fixup cycle and holds the result until consumed.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       func3_q;
    logic             negA_q;
    logic             negB_q;
    logic             divZero_q;
    logic             ovf_q;
    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  accHi_q;
    logic [XLEN-1:0]  accLo_q;
    logic [XLEN-1:0]  result_q;
    logic             resultValid_q;
    logic             busy_q;
    logic             startReady_q;

    logic [XLEN-1:0]  accHi_d;
    logic [XLEN-1:0]  accLo_d;

    logic             inNegA;
    logic             inNegB;
    logic [XLEN-1:0]  inMagA;
    logic [XLEN-1:0]  inMagB;
    logic             inDivZero;
    logic             inOvf;

    logic [XLEN:0]    mulSum;
    logic [XLEN:0]    divShift;
    logic [XLEN:0]    divDiff;

    logic [XLEN-1:0]  fixResult;

    assign bus.startReady  = startReady_q;
    assign bus.result      = result_q;
    assign bus.resultValid = resultValid_q;
    assign bus.busy        = busy_q;

    // Decode the incoming request: sign flags, magnitudes and the two divide
    // cases that bypass the iteration loop.
    always_comb begin
        inNegA    = is_signed_a(bus.func3) && bus.opA[XLEN-1];
        inNegB    = is_signed_b(bus.func3) && bus.opB[XLEN-1];
        inMagA    = inNegA ? -bus.opA : bus.opA;
        inMagB    = inNegB ? -bus.opB : bus.opB;
        inDivZero = is_div(bus.func3) && (bus.opB == '0);
        inOvf     = is_div(bus.func3) && is_signed_a(bus.func3) &&
                    (bus.opA == MIN_INT) && (bus.opB == '1);
    end

    // One loop iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        divShift = {accHi_q, accLo_q[XLEN-1]};
        divDiff  = divShift - {1'b0, mcand_q};
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        if (is_div(func3_q)) begin
            if (!divDiff[XLEN]) begin
                accHi_d = divDiff[XLEN-1:0];
                accLo_d = {accLo_q[XLEN-2:0], 1'b1};
            end else begin
                accHi_d = divShift[XLEN-1:0];
                accLo_d = {accLo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            accHi_d = mulSum[XLEN:1];
            accLo_d = {mulSum[0], accLo_q[XLEN-1:1]};
        end
    end

    muldiv_sign_fix u_sign_fix (
        .func3_i   (func3_q),
        .negA_i    (negA_q),
        .negB_i    (negB_q),
        .divZero_i (divZero_q),
        .ovf_i     (ovf_q),
        .hi_i      (accHi_q),
        .lo_i      (accLo_q),
        .result_o  (fixResult)
    );

    // Control FSM with registered handshake outputs; flush overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            func3_q       <= '0;
            negA_q        <= 1'b0;
            negB_q        <= 1'b0;
            divZero_q     <= 1'b0;
            ovf_q         <= 1'b0;
            mcand_q       <= '0;
            accHi_q       <= '0;
            accLo_q       <= '0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            busy_q        <= 1'b0;
            startReady_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.startValid && startReady_q && !bus.flush) begin
                        func3_q      <= bus.func3;
                        negA_q       <= inNegA;
                        negB_q       <= inNegB;
                        divZero_q    <= inDivZero;
                        ovf_q        <= inOvf;
                        cnt_q        <= '0;
                        accHi_q      <= '0;
                        busy_q       <= 1'b1;
                        startReady_q <= 1'b0;
                        if (is_div(bus.func3)) begin
                            mcand_q <= inMagB;
                            accLo_q <= inMagA;
                        end else begin
                            mcand_q <= inMagA;
                            accLo_q <= inMagB;
                        end
                        state_q <= (inDivZero || inOvf) ? FIXUP : CALC;
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        startReady_q <= 1'b1;
                    end else begin
                        accHi_q <= accHi_d;
                        accLo_q <= accLo_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(XLEN-1)) begin
                            state_q <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    if (bus.flush) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        startReady_q <= 1'b1;
                    end else begin
                        result_q      <= fixResult;
                        resultValid_q <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.flush || bus.resultReady) begin
                        resultValid_q <= 1'b0;
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        startReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    resultValid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    startReady_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule
